fp_mul_serial_lmfp: RTL and testbench

- Parametrised byte-serial floating-point multiplier; successor to the fixed FP16 logarithmic multiplier.
- Operands A and B arrive over two BUS_W-wide lanes, LSB byte first, with a valid/ready handshake.
- The product is computed in one of two selectable modes: Mitchell logarithmic approximation or truncated exact.
- The result streams out over BUS_W with valid/ready/last, plus overflow/underflow/zero/NaN flags.
- Sits between the chip-pin byte interface and the user-visible result path.

---
 rtl/fp_mul_serial_lmfp.sv | 266 ++++++++++++++++++++++++++
 tb/tb_fp_mul_serial_lmfp.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_serial_lmfp.sv
// ---------------------------------------------------------------------------
// fp_mul_serial_lmfp
//
// Byte-serial floating-point multiplier. Operands A and B arrive LSB slice
// first over two BUS_W-wide lanes. Once a full word of each has been
// collected, the product is formed in a single cycle, using either the
// Mitchell logarithmic approximation (mode=0) or a truncated exact product
// (mode=1). The result is then streamed out LSB slice first.
// Denormal inputs are flushed to zero.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts an operand beat (high while collecting)
//   in_a       operand A slice
//   in_b       operand B slice
//   mode       0 = Mitchell, 1 = exact truncated; sampled on beat 0 only
//   out_valid  result beat valid
//   out_ready  downstream accepts a result beat
//   out_data   result slice; unused high bits of the last slice are zero
//   out_last   high on the final result beat
//   flag_ovf   exponent overflow, result forced to infinity
//   flag_unf   exponent underflow, result forced to zero
//   flag_zero  result is a (signed) zero
//   flag_nan   result is the canonical NaN
//   (all flags are held for every beat of the result)
// ---------------------------------------------------------------------------
module fp_mul_serial_lmfp #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_a,
    input  logic [BUS_W-1:0] in_b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_last,
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_zero,
    output logic             flag_nan
);

    localparam int WORD_W = 1 + EXP_W + MAN_W;
    localparam int NBEATS = (WORD_W + BUS_W - 1) / BUS_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int E2_W   = EXP_W + 2;   // signed working width of the exponent
    localparam int P_W    = 2 * MAN_W + 2;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [E2_W-1:0]  BIAS_E    = E2_W'(BIAS);
    localparam logic [E2_W-1:0]  EXP_MAX_E = E2_W'((1 << EXP_W) - 1);
    localparam logic [MAN_W-1:0] NAN_MAN   = {1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        SEND    = 2'd2
    } state_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
        logic nan;
    } flags_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic [WORD_W-1:0]   res_q, res_d;
    logic                mode_q, mode_d;
    flags_t              flags_q, flags_d;

    // -----------------------------------------------------------------------
    // Product datapath (purely combinational on the collected operands)
    // -----------------------------------------------------------------------
    logic                sa, sb, s_out;
    logic [EXP_W-1:0]    ea, eb;
    logic [MAN_W-1:0]    ma, mb;
    logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [MAN_W:0]      m_sum;
    logic [P_W-1:0]      m_prod;
    logic [MAN_W+1:0]    prod_top;     // product bits [2*MAN_W+1 : MAN_W]
    logic                carry;
    logic [MAN_W-1:0]    m_out;
    logic [E2_W-1:0]     e_raw;
    logic                e_ovf, e_unf;
    logic [WORD_W-1:0]   prod_res;
    flags_t              prod_flags;

    always_comb begin
        sa = a_q[WORD_W-1];
        sb = b_q[WORD_W-1];
        ea = a_q[WORD_W-2:MAN_W];
        eb = b_q[WORD_W-2:MAN_W];
        ma = a_q[MAN_W-1:0];
        mb = b_q[MAN_W-1:0];

        s_out  = sa ^ sb;
        a_nan  = (ea == EXP_ONES) && (ma != '0);
        b_nan  = (eb == EXP_ONES) && (mb != '0);
        a_inf  = (ea == EXP_ONES) && (ma == '0);
        b_inf  = (eb == EXP_ONES) && (mb == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);

        m_sum    = {1'b0, ma} + {1'b0, mb};
        m_prod   = P_W'({1'b1, ma}) * P_W'({1'b1, mb});
        prod_top = (MAN_W + 2)'(m_prod >> MAN_W);

        if (mode_q) begin
            // Exact: renormalise by one place when the product reaches [2,4).
            carry = prod_top[MAN_W+1];
            m_out = carry ? prod_top[MAN_W:1] : prod_top[MAN_W-1:0];
        end else begin
            // Mitchell: log2(1+m) ~ m, so the mantissas simply add and a carry
            // out of the sum bumps the exponent.
            carry = m_sum[MAN_W];
            m_out = m_sum[MAN_W-1:0];
        end

        // Modular arithmetic in E2_W bits yields the two's-complement value.
        e_raw = {2'b00, ea} + {2'b00, eb} + {{(E2_W - 1){1'b0}}, carry} - BIAS_E;
        e_ovf = $signed(e_raw) >= $signed(EXP_MAX_E);
        e_unf = e_raw[E2_W-1] || (e_raw == '0);

        // Special cases are tested in priority order: NaN, inf, zero input,
        // then the exponent range of the computed product.
        prod_flags = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            prod_res        = {s_out, EXP_ONES, NAN_MAN};
            prod_flags.nan  = 1'b1;
        end else if (a_inf || b_inf) begin
            prod_res        = {s_out, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            prod_res        = {s_out, {(WORD_W - 1){1'b0}}};
            prod_flags.zero = 1'b1;
        end else if (e_ovf) begin
            prod_res        = {s_out, EXP_ONES, {MAN_W{1'b0}}};
            prod_flags.ovf  = 1'b1;
        end else if (e_unf) begin
            prod_res        = {s_out, {(WORD_W - 1){1'b0}}};
            prod_flags.unf  = 1'b1;
            prod_flags.zero = 1'b1;
        end else begin
            prod_res        = {s_out, e_raw[EXP_W-1:0], m_out};
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        mode_d  = mode_q;
        flags_d = flags_q;

        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    // Only bits below WORD_W are stored; any lane bits of the
                    // final slice beyond the word are dropped.
                    for (int i = 0; i < WORD_W; i++) begin
                        if (int'(cnt_q) == i / BUS_W) begin
                            a_d[i] = in_a[i % BUS_W];
                            b_d[i] = in_b[i % BUS_W];
                        end
                    end
                    if (cnt_q == '0) begin
                        mode_d = mode;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMPUTE: begin
                res_d   = prod_res;
                flags_d = prod_flags;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        flags_d = '0;
                        state_d = COLLECT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            flags_q <= flags_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == SEND);
        out_last  = (state_q == SEND) && (cnt_q == LAST_BEAT);
        out_data  = '0;
        if (state_q == SEND) begin
            for (int i = 0; i < WORD_W; i++) begin
                if (int'(cnt_q) == i / BUS_W) begin
                    out_data[i % BUS_W] = res_q[i];
                end
            end
        end
        flag_ovf  = flags_q.ovf;
        flag_unf  = flags_q.unf;
        flag_zero = flags_q.zero;
        flag_nan  = flags_q.nan;
    end

endmodule

// File: tb/tb_fp_mul_serial_lmfp.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_serial_lmfp
//
// Directed bench for fp_mul_serial_lmfp at default parameters (FP16,
// 8-bit lanes, two beats per word). Inputs are driven and outputs sampled
// on the falling clock edge. Flags are compared as {ovf, unf, zero, nan}.
// ---------------------------------------------------------------------------
module tb_fp_mul_serial_lmfp;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       flag_ovf, flag_unf, flag_zero, flag_nan;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_mul_serial_lmfp dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_zero (flag_zero),
        .flag_nan  (flag_nan)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {flag_ovf, flag_unf, flag_zero, flag_nan};
    endfunction

    // Two operand beats; mode_b0 on beat 0, mode_b1 on beat 1 (must be ignored).
    // Ends just after the edge that accepts the last beat, then checks the
    // COMPUTE cycle and that the first result beat appears one cycle later.
    task automatic load(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic mode_b0, input logic mode_b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = a[k*8 +: 8];
            in_b     = b[k*8 +: 8];
            mode     = (k == 0) ? mode_b0 : mode_b1;
            check({tag, "_in_ready"}, in_ready, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_compute_valid"}, out_valid, 1'b0);
        check({tag, "_compute_ready"}, in_ready, 1'b0);
        @(negedge clk);
        check({tag, "_latency"}, out_valid, 1'b1);
    endtask

    // Receive both result beats with out_ready high; starts on the negedge
    // where the first beat is already valid.
    task automatic recv(input string tag, input logic [15:0] exp_res, input logic [3:0] exp_flags);
        int waited = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (out_valid !== 1'b1) begin
            check({tag, "_timeout"}, out_valid, 1'b1);
        end else begin
            for (int k = 0; k < 2; k++) begin
                check({tag, "_data"}, out_data, exp_res[k*8 +: 8]);
                check({tag, "_last"}, out_last, (k == 1));
                check({tag, "_flags"}, flags(), exp_flags);
                @(negedge clk);
            end
            check({tag, "_done_valid"}, out_valid, 1'b0);
            check({tag, "_flags_clr"}, flags(), 4'b0000);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_last", out_last, 1'b0);
        check("rst_flags", flags(), 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // 1.5 x 1.5
        load("m0_15x15", 16'h3E00, 16'h3E00, 1'b0, 1'b0);
        recv("m0_15x15", 16'h4000, 4'b0000);
        load("m1_15x15", 16'h3E00, 16'h3E00, 1'b1, 1'b1);
        recv("m1_15x15", 16'h4080, 4'b0000);

        // 1.5 x 1.25: exact 1.875, Mitchell 1.75
        load("m1_15x125", 16'h3E00, 16'h3D00, 1'b1, 1'b1);
        recv("m1_15x125", 16'h3F80, 4'b0000);
        load("m0_15x125", 16'h3E00, 16'h3D00, 1'b0, 1'b0);
        recv("m0_15x125", 16'h3F00, 4'b0000);

        // 2 x 3 and sign
        load("m0_2x3", 16'h4000, 16'h4200, 1'b0, 1'b0);
        recv("m0_2x3", 16'h4600, 4'b0000);
        load("m0_n2x3", 16'hC000, 16'h4200, 1'b0, 1'b0);
        recv("m0_n2x3", 16'hC600, 4'b0000);

        // Mode toggled on beat 1 must not affect the operation
        load("mode_late", 16'h3E00, 16'h3E00, 1'b0, 1'b1);
        recv("mode_late", 16'h4000, 4'b0000);

        // Overflow, NaN, underflow, zero input
        load("ovf", 16'h7800, 16'hF800, 1'b0, 1'b0);
        recv("ovf", 16'hFC00, 4'b1000);
        load("inf_x_zero", 16'h7C00, 16'h0000, 1'b0, 1'b0);
        recv("inf_x_zero", 16'h7E00, 4'b0001);
        load("inf_x_norm", 16'h7C00, 16'hBC00, 1'b0, 1'b0);
        recv("inf_x_norm", 16'hFC00, 4'b0000);
        load("unf", 16'h0400, 16'h0400, 1'b0, 1'b0);
        recv("unf", 16'h0000, 4'b0110);
        load("neg_zero", 16'h8000, 16'h3C00, 1'b0, 1'b0);
        recv("neg_zero", 16'h8000, 4'b0010);

        // Backpressure on beat 0
        out_ready = 1'b0;
        load("bp", 16'h4000, 16'h4200, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", out_data, 8'h00);
            check("bp_hold_last", out_last, 1'b0);
            check("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        recv("bp", 16'h4600, 4'b0000);

        // Reset after operand beat 0, then a fresh full load
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 8'hAA;
        in_b     = 8'h55;
        mode     = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 8'h00);
        check("mid_rst_flags", flags(), 4'b0000);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load("after_rst", 16'h3C00, 16'h3C00, 1'b0, 1'b0);
        recv("after_rst", 16'h3C00, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
